// File: rtl/pipe_rca_pkg.sv
// rtl/pipe_rca_pkg.sv - default sizing and segment-width helper for pipe_rca
package pipe_rca_pkg;

  localparam int PIPE_RCA_WIDTH_DEF  = 8;
  localparam int PIPE_RCA_STAGES_DEF = 2;

  // Bits handled by each pipeline stage.
  function automatic int seg_width(input int width, input int stages);
    return width / stages;
  endfunction

endpackage

// File: rtl/pipe_rca_seg.sv
// rtl/pipe_rca_seg.sv - combinational ripple-carry adder for one pipeline segment
module rca_seg #(
  parameter int W = 4
) (
  input  logic [W-1:0] a_i,
  input  logic [W-1:0] b_i,
  input  logic         cin_i,
  output logic [W-1:0] s_o,
  output logic         cout_o,
  output logic         c_msb_o
);

  logic [W:0] c;

  // Ripple the carry bit by bit; c[i] is the carry into bit i.
  always_comb begin
    c    = '0;
    s_o  = '0;
    c[0] = cin_i;
    for (int i = 0; i < W; i++) begin
      s_o[i]   = a_i[i] ^ b_i[i] ^ c[i];
      c[i+1]   = (a_i[i] & b_i[i]) | (c[i] & (a_i[i] ^ b_i[i]));
    end
  end

  assign cout_o  = c[W];
  // Carry into the top bit of the segment; only the last stage's value matters for overflow.
  assign c_msb_o = c[W-1];

endmodule

// File: rtl/pipe_rca.sv
// rtl/pipe_rca.sv - segmented, pipelined ripple-carry adder/subtractor with valid/ready flow control
module pipe_rca
  import pipe_rca_pkg::*;
#(
  parameter int WIDTH  = PIPE_RCA_WIDTH_DEF,
  parameter int STAGES = PIPE_RCA_STAGES_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             cin,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] sum,
  output logic             cout,
  output logic             ovf
);

  localparam int SEG = seg_width(WIDTH, STAGES);

  if (WIDTH < 2 || STAGES < 1 || (WIDTH % STAGES) != 0) begin : g_bad_params
    $error("pipe_rca: WIDTH must be >= 2 and a multiple of STAGES");
  end

  // Index k is the input of stage k; index STAGES is the output register set.
  // Operands are kept right-aligned: each stage consumes the low SEG bits and
  // shifts the rest down. Completed sum bits enter from the top and shift down,
  // so after the last stage segment 0 sits at bit 0.
  logic [WIDTH-1:0] a_p [0:STAGES];
  logic [WIDTH-1:0] b_p [0:STAGES];
  logic [WIDTH-1:0] s_p [0:STAGES];
  logic [STAGES:0]  v_p;
  logic [STAGES:0]  c_p;
  logic [STAGES:0]  o_p;
  logic             adv;

  // Subtraction is a + ~b + 1, so invert b and force the carry-in up front.
  assign a_p[0] = a;
  assign b_p[0] = sub ? ~b : b;
  assign s_p[0] = '0;
  assign v_p[0] = in_valid;
  assign c_p[0] = sub ? 1'b1 : cin;
  assign o_p[0] = 1'b0;

  // The whole pipe moves together whenever the output slot is free or draining.
  assign adv      = !v_p[STAGES] || out_ready;
  assign in_ready = adv;

  for (genvar k = 0; k < STAGES; k++) begin : g_stage
    logic [SEG-1:0]       seg_s;
    logic                 seg_co;
    logic                 seg_cm;
    logic [WIDTH+SEG-1:0] s_cat;
    logic                 unused_low;
    logic [WIDTH-1:0]     a_d, b_d, s_d;
    logic                 v_d, c_d, o_d;
    logic [WIDTH-1:0]     a_q, b_q, s_q;
    logic                 v_q, c_q, o_q;

    rca_seg #(.W(SEG)) u_seg (
      .a_i    (a_p[k][SEG-1:0]),
      .b_i    (b_p[k][SEG-1:0]),
      .cin_i  (c_p[k]),
      .s_o    (seg_s),
      .cout_o (seg_co),
      .c_msb_o(seg_cm)
    );

    assign s_cat      = {seg_s, s_p[k]};
    assign unused_low = ^s_cat[SEG-1:0];

    assign a_d = a_p[k] >> SEG;
    assign b_d = b_p[k] >> SEG;
    assign s_d = s_cat[WIDTH+SEG-1:SEG];
    assign v_d = v_p[k];
    assign c_d = seg_co;
    // Meaningful only in the last stage, where the segment MSB is the word MSB.
    assign o_d = seg_cm ^ seg_co;

    // Stage register: loads on advance, holds under back-pressure, clears on reset.
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        v_q <= 1'b0;
        c_q <= 1'b0;
        o_q <= 1'b0;
        a_q <= '0;
        b_q <= '0;
        s_q <= '0;
      end else if (adv) begin
        v_q <= v_d;
        c_q <= c_d;
        o_q <= o_d;
        a_q <= a_d;
        b_q <= b_d;
        s_q <= s_d;
      end
    end

    assign a_p[k+1] = a_q;
    assign b_p[k+1] = b_q;
    assign s_p[k+1] = s_q;
    assign v_p[k+1] = v_q;
    assign c_p[k+1] = c_q;
    assign o_p[k+1] = o_q;
  end

  // Operands are fully consumed by the end; intermediate overflow bits are don't-care.
  logic unused_top;
  assign unused_top = ^{a_p[STAGES], b_p[STAGES], o_p};

  assign out_valid = v_p[STAGES];
  assign sum       = s_p[STAGES];
  assign cout      = c_p[STAGES];
  assign ovf       = o_p[STAGES];

endmodule

// File: tb/tb_pipe_rca.sv
// tb/tb_pipe_rca.sv - self-checking bench for pipe_rca (WIDTH=8, STAGES=2)
module tb_pipe_rca;

  localparam int W = 8;
  localparam int S = 2;

  logic         clk, rst;
  logic         in_valid, in_ready, out_valid, out_ready;
  logic [W-1:0] a, b, sum;
  logic         cin, sub, cout, ovf;

  int compared   = 0;
  int mismatched = 0;

  logic [W+1:0] expq [$];

  pipe_rca #(.WIDTH(W), .STAGES(S)) dut (
    .clk      (clk),
    .rst      (rst),
    .in_valid (in_valid),
    .in_ready (in_ready),
    .a        (a),
    .b        (b),
    .cin      (cin),
    .sub      (sub),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .sum      (sum),
    .cout     (cout),
    .ovf      (ovf)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Reference: plain integer arithmetic; overflow from operand/result signs.
  function automatic logic [W+1:0] model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                         input logic cv, input logic sv);
    logic [W-1:0] bb;
    logic [W:0]   full;
    logic         ci, ov;
    bb   = sv ? (~bv) : bv;
    ci   = sv ? 1'b1 : cv;
    full = {1'b0, av} + {1'b0, bb} + {{W{1'b0}}, ci};
    ov   = (av[W-1] == bb[W-1]) && (full[W-1] != av[W-1]);
    return {ov, full[W], full[W-1:0]};
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: sample at negedge, score outputs against the queue, record accepts.
  task automatic step(input logic iv, input logic ordy, output logic ov_seen);
    logic [W+1:0] e;
    in_valid  = iv;
    out_ready = ordy;
    @(negedge clk);
    ov_seen = out_valid;
    check("in_ready_rule", {31'b0, in_ready}, {31'b0, (!out_valid) || ordy});
    if (out_valid === 1'b1) begin
      if (expq.size() == 0) begin
        check("unexpected_out", {31'b0, out_valid}, 32'd0);
      end else begin
        e = expq[0];
        check("sum", {24'b0, sum}, {24'b0, e[W-1:0]});
        check("cout", {31'b0, cout}, {31'b0, e[W]});
        check("ovf", {31'b0, ovf}, {31'b0, e[W+1]});
        if (ordy) void'(expq.pop_front());
      end
    end
    if (iv && in_ready === 1'b1) expq.push_back(model(a, b, cin, sub));
    @(posedge clk);
    #1;
  endtask

  task automatic rstep(input logic iv, input logic ordy, output logic ov_seen);
    a   = W'($urandom);
    b   = W'($urandom);
    cin = 1'($urandom);
    sub = 1'($urandom);
    step(iv, ordy, ov_seen);
  endtask

  // Directed single operation with explicit latency-2 timing and constant expectations.
  task automatic single(input string tag, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic cv, input logic sv,
                        input logic [W-1:0] es, input logic ec, input logic eo);
    a = av; b = bv; cin = cv; sub = sv;
    in_valid = 1'b1; out_ready = 1'b1;
    @(negedge clk);
    check({tag, "_in_ready"}, {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    in_valid = 1'b0; a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    @(negedge clk);
    check({tag, "_early"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_valid"}, {31'b0, out_valid}, 32'd1);
    check({tag, "_sum"}, {24'b0, sum}, {24'b0, es});
    check({tag, "_cout"}, {31'b0, cout}, {31'b0, ec});
    check({tag, "_ovf"}, {31'b0, ovf}, {31'b0, eo});
    @(posedge clk); #1;
    @(negedge clk);
    check({tag, "_once"}, {31'b0, out_valid}, 32'd0);
    @(posedge clk); #1;
  endtask

  initial begin
    logic ov;
    logic str_pat [7];
    logic str_iv  [7];
    logic bp_ordy [10];
    str_pat = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0};
    str_iv  = '{1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0};
    bp_ordy = '{1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1};

    rst = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
    a = '0; b = '0; cin = 1'b0; sub = 1'b0;
    #12;
    check("rst_out_valid", {31'b0, out_valid}, 32'd0);
    check("rst_sum", {24'b0, sum}, 32'd0);
    check("rst_cout", {31'b0, cout}, 32'd0);
    check("rst_ovf", {31'b0, ovf}, 32'd0);
    check("rst_in_ready", {31'b0, in_ready}, 32'd1);
    @(posedge clk); #1;
    rst = 1'b1;

    single("add",     8'h35, 8'h5A, 1'b0, 1'b0, 8'h8F, 1'b0, 1'b1);
    single("sub_c1",  8'h10, 8'h01, 1'b1, 1'b1, 8'h0F, 1'b1, 1'b0);
    single("sub_c0",  8'h10, 8'h01, 1'b0, 1'b1, 8'h0F, 1'b1, 1'b0);
    single("wrap",    8'hFF, 8'h01, 1'b1, 1'b0, 8'h01, 1'b1, 1'b0);
    single("sub_neg", 8'h80, 8'h01, 1'b0, 1'b1, 8'h7F, 1'b1, 1'b1);

    // Four back-to-back operands, results expected on four consecutive cycles.
    for (int i = 0; i < 7; i++) begin
      rstep(str_iv[i], 1'b1, ov);
      check($sformatf("stream_valid_%0d", i), {31'b0, ov}, {31'b0, str_pat[i]});
    end
    check("stream_drained", expq.size(), 32'd0);

    // Back-pressure for three cycles in the middle of a running stream.
    for (int i = 0; i < 10; i++) begin
      rstep(1'b1, bp_ordy[i], ov);
      if (!bp_ordy[i]) begin
        check($sformatf("bp_held_valid_%0d", i), {31'b0, ov}, 32'd1);
        check($sformatf("bp_in_ready_%0d", i), {31'b0, in_ready}, 32'd0);
      end
    end
    for (int i = 0; i < 20 && expq.size() != 0; i++) rstep(1'b0, 1'b1, ov);
    check("bp_drained", expq.size(), 32'd0);

    // Random traffic on both sides.
    for (int i = 0; i < 300; i++) rstep(($urandom_range(0, 3) != 0), ($urandom_range(0, 9) < 7), ov);
    for (int i = 0; i < 20 && expq.size() != 0; i++) rstep(1'b0, 1'b1, ov);
    check("rand_drained", expq.size(), 32'd0);

    // Asynchronous reset with two operations in flight.
    rstep(1'b1, 1'b1, ov);
    rstep(1'b1, 1'b1, ov);
    in_valid = 1'b0;
    check("pre_rst_valid", {31'b0, out_valid}, 32'd1);
    #2;
    rst = 1'b0;
    #1;
    check("arst_out_valid", {31'b0, out_valid}, 32'd0);
    check("arst_sum", {24'b0, sum}, 32'd0);
    check("arst_cout", {31'b0, cout}, 32'd0);
    check("arst_ovf", {31'b0, ovf}, 32'd0);
    check("arst_in_ready", {31'b0, in_ready}, 32'd1);
    expq.delete();
    @(posedge clk); #1;
    rst = 1'b1;
    for (int i = 0; i < 4; i++) begin
      rstep(1'b0, 1'b1, ov);
      check($sformatf("post_rst_quiet_%0d", i), {31'b0, ov}, 32'd0);
    end
    single("post_rst", 8'h7F, 8'h01, 1'b0, 1'b0, 8'h80, 1'b0, 1'b1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
